alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
Multi-cycle control FSM for the 8-bit RISC datapath. It fetches 16-bit instructions over a req/ack instruction port and decodes them. It drives ALU opcode, register-file read/write controls and the data-memory handshake, then advances the 8-bit PC. It sits between instruction memory, register file, ALU and data memory, and owns the program counter and the equality flag.

Parameters:
PC_W, 8, program counter width
RESET_PC, 8'h00, PC value after reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
imem_req  out  1  instruction fetch request
imem_addr  out  PC_W  fetch address (= pc)
imem_ack  in  1  fetch data valid this cycle
imem_data  in  16  instruction: [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2
rf_raddr_a  out  4  register read port A address (rs1)
rf_raddr_b  out  4  register read port B address (rs2)
rf_we  out  1  register write enable, one-cycle pulse
rf_waddr  out  4  register write address (rd)
rf_wsel  out  1  write-data select: 0 = ALU out, 1 = dmem read data
alu_op  out  4  ALU opcode
alu_out  in  8  ALU result; bit 0 samples the EQ result
dmem_req  out  1  data memory request
dmem_we  out  1  1 = store, 0 = load; valid with dmem_req
dmem_ack  in  1  data access complete
halted  out  1  core in HALT state
pc  out  PC_W  current program counter

Behaviour:
- Reset values (synchronous, rst=1 at clk edge): state=FETCH, pc=RESET_PC, eq_flag=0, ir=0, all request/enable outputs 0, alu_op=4'b0000, halted=0. rst overrides any pending handshake; an ack arriving in the reset cycle is ignored.
- Opcode map:
  - 0000 NOP
  - 0001 HALT
  - 0010 ADD, 0011 SUB, 0100 SHL, 0101 SHR, 0110 AND, 0111 OR, 1000 XOR, 1001 EQ
  - 1010 LD: rd <= mem[rs1]
  - 1011 ST: mem[rs1] <= rs2
  - 1100 JMP: pc <= {rs1,rs2}
  - 1101 BT: if eq_flag, pc <= {rs1,rs2}
  - 1110 and 1111: treated as NOP.
- FETCH: imem_req held high until imem_ack. On ack, ir <= imem_data and go to DECODE. Minimum 1 cycle; wait states unbounded.
- DECODE (1 cycle): drive rf_raddr_a/b from ir.
  - ALU ops go to EXEC.
  - LD/ST go to MEM.
  - JMP/BT update pc, then go to FETCH.
  - NOP and undefined ops: pc <= pc+1, go to FETCH.
  - HALT goes to HALT.
- EXEC (1 cycle): alu_op=ir[15:12], rf_we=1, rf_wsel=0, rf_waddr=rd, pc <= pc+1, then FETCH. EQ additionally latches eq_flag <= alu_out[0]. alu_op returns to 0000 outside EXEC.
- MEM: dmem_req=1, dmem_we=(op==ST), held until dmem_ack. On ack, a LD pulses rf_we with rf_wsel=1 in the same cycle; pc <= pc+1; then FETCH.
- HALT: halted=1. Stays in HALT until rst; no requests issued.
- PC arithmetic is modulo 2^PC_W: pc=8'hFF+1 wraps to 8'h00. Branch targets are absolute.
- Latency: ALU instruction = fetch wait + 3 cycles. LD/ST = fetch wait + 2 + dmem wait. JMP/NOP = fetch wait + 2.
- Requests are never dropped mid-handshake. An ack while the matching req is low is ignored.

Optional Feature:
ALU_SEQ_TIMEOUT_EN
- Defined: adds an 8-bit wait counter that counts cycles spent in FETCH or MEM without an ack.
  - At 255 the FSM enters FAULT: halted=1, requests dropped, adds output port fault (1 bit, reset 0).
  - Exit only by rst.
- Undefined: no counter, no fault port; waits are unbounded.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams (OP_NOP … OP_BT)
  - state enum typedef (FETCH, DECODE, EXEC, MEM, HALT, FAULT)
  - instruction field slice constants.
- One sub-module, alu_seq_decode, is natural: combinational op→class decode (is_alu, is_mem, is_store, is_branch, is_halt).

Test Plan:
- Reset then imem returns 16'h2312 (ADD r3,r1,r2) with ack after 2 waits -> alu_op=0010, rf_we pulse with rf_waddr=3, pc 0→1.
- EQ r0,r1,r2 with alu_out=8'h01, then BT 8'h40 -> eq_flag=1, pc=8'h40. Repeat with alu_out=0 -> pc increments.
- LD r5,[r4] with dmem_ack after 3 cycles -> dmem_req high 3 cycles, dmem_we=0, rf_we pulse with rf_wsel=1, rf_waddr=5. ST -> dmem_we=1, no rf_we.
- JMP 8'hFF, then NOP at FF -> pc wraps to 8'h00.
- HALT -> halted=1, no imem_req for 20 cycles. rst asserted during a MEM wait -> pc=RESET_PC, dmem_req=0 next cycle.
- With ALU_SEQ_TIMEOUT_EN: imem_ack held low -> fault=1 after 255 wait cycles.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states and instruction field slices
// for the alu_sequencer control unit.
package alu_seq_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_HALT = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_EQ   = 4'h9;
  localparam logic [3:0] OP_LD   = 4'hA;
  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_BT   = 4'hD;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS1_HI = 7;
  localparam int RS1_LO = 4;
  localparam int RS2_HI = 3;
  localparam int RS2_LO = 0;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    HALT,
    FAULT
  } state_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Opcode to instruction-class decode for alu_sequencer.
// Opcodes 0000, 1110 and 1111 fall through to no class (NOP).
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] op,
  output logic       is_alu,
  output logic       is_mem,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_cond,
  output logic       is_halt
);

  always_comb begin
    is_alu    = 1'b0;
    is_mem    = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_cond   = 1'b0;
    is_halt   = 1'b0;
    unique case (1'b1)
      (op >= OP_ADD) && (op <= OP_EQ): is_alu = 1'b1;
      (op == OP_LD): is_mem = 1'b1;
      (op == OP_ST): begin
        is_mem   = 1'b1;
        is_store = 1'b1;
      end
      (op == OP_JMP): is_branch = 1'b1;
      (op == OP_BT): begin
        is_branch = 1'b1;
        is_cond   = 1'b1;
      end
      (op == OP_HALT): is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/execute control FSM for the 8-bit datapath.
// Define ALU_SEQ_TIMEOUT_EN to add the handshake watchdog and fault port.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic [3:0]      rf_raddr_a,
  output logic [3:0]      rf_raddr_b,
  output logic            rf_we,
  output logic [3:0]      rf_waddr,
  output logic            rf_wsel,
  output logic [3:0]      alu_op,
  input  logic [7:0]      alu_out,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
`ifdef ALU_SEQ_TIMEOUT_EN
  output logic            fault,
`endif
  output logic            halted,
  output logic [PC_W-1:0] pc
);

  state_t          state;
  logic [15:0]     ir;
  logic            eq_flag;
  logic            rf_we_q;
  logic            ld_done;
  logic [3:0]      op;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] target;
  logic            is_alu;
  logic            is_mem;
  logic            is_store;
  logic            is_branch;
  logic            is_cond;
  logic            is_halt;
  logic            unused_alu_bits;

  assign op         = ir[OP_HI:OP_LO];
  assign rf_raddr_a = ir[RS1_HI:RS1_LO];
  assign rf_raddr_b = ir[RS2_HI:RS2_LO];
  assign rf_waddr   = ir[RD_HI:RD_LO];
  assign imem_addr  = pc;
  assign pc_inc     = pc + PC_W'(1);
  assign target     = PC_W'({ir[RS1_HI:RS1_LO],
                             ir[RS2_HI:RS2_LO]});

  // Load write-back must land in the ack cycle, so it bypasses the register.
  assign ld_done = (state == MEM) && dmem_req
                 && dmem_ack && !dmem_we;
  assign rf_we   = rf_we_q | ld_done;

  assign unused_alu_bits = ^alu_out[7:1];

  alu_seq_decode u_decode (
    .op        (op),
    .is_alu    (is_alu),
    .is_mem    (is_mem),
    .is_store  (is_store),
    .is_branch (is_branch),
    .is_cond   (is_cond),
    .is_halt   (is_halt)
  );

`ifdef ALU_SEQ_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       hs_wait;

  assign hs_wait =
    ((state == FETCH) && !(imem_req && imem_ack)) ||
    ((state == MEM) && !(dmem_req && dmem_ack));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      eq_flag  <= 1'b0;
      ir       <= '0;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      rf_we_q  <= 1'b0;
      rf_wsel  <= 1'b0;
      alu_op   <= OP_NOP;
      halted   <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
      wait_cnt <= '0;
      fault    <= 1'b0;
`endif
    end else begin
      rf_we_q <= 1'b0;
      alu_op  <= OP_NOP;
      unique case (state)
        FETCH: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            ir       <= imem_data;
            imem_req <= 1'b0;
            state    <= DECODE;
          end
        end
        DECODE: begin
          unique case (1'b1)
            is_alu: begin
              alu_op  <= op;
              rf_we_q <= 1'b1;
              rf_wsel <= 1'b0;
              state   <= EXEC;
            end
            is_mem: begin
              dmem_req <= 1'b1;
              dmem_we  <= is_store;
              rf_wsel  <= !is_store;
              state    <= MEM;
            end
            is_halt: begin
              halted <= 1'b1;
              state  <= HALT;
            end
            is_branch: begin
              pc <= (!is_cond || eq_flag) ? target : pc_inc;
              imem_req <= 1'b1;
              state    <= FETCH;
            end
            default: begin
              pc       <= pc_inc;
              imem_req <= 1'b1;
              state    <= FETCH;
            end
          endcase
        end
        EXEC: begin
          if (op == OP_EQ) eq_flag <= alu_out[0];
          pc       <= pc_inc;
          imem_req <= 1'b1;
          state    <= FETCH;
        end
        MEM: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            pc       <= pc_inc;
            imem_req <= 1'b1;
            state    <= FETCH;
          end
        end
        HALT: ;
        FAULT: ;
        default: state <= FETCH;
      endcase
`ifdef ALU_SEQ_TIMEOUT_EN
      // The 255th consecutive unacknowledged cycle trips the watchdog.
      if (hs_wait) begin
        if (wait_cnt == 8'd254) begin
          state    <= FAULT;
          fault    <= 1'b1;
          halted   <= 1'b1;
          imem_req <= 1'b0;
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end else begin
        wait_cnt <= '0;
      end
`endif
    end
  end

endmodule
